mem_access_unit: RTL and testbench

- Load/store unit between the processor execute stage and the 32-bit word-addressed data RAM.
- Accepts byte-addressed load/store requests over a valid/ready handshake and range-checks them.
- Translates each request to a RAM word index; performs read-modify-write for byte and halfword stores.
- Returns load data (sign/zero extended) or an error over a valid/ready response channel.

---
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit bridging byte-addressed requests to a word-addressed RAM, with sub-word read-modify-write.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of ignoring low bits.
module mem_access_unit #(
    parameter int          MEM_WORDS = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    state_t      r_state;
    state_t      w_nextState;

    logic [31:0] r_ramAddr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rspRdata;
    logic        r_rspErr;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_we;
    logic        r_signed;

    logic [31:0] w_offsetAddr;
    logic [31:0] w_index;
    logic        w_misalign;
    logic        w_reqErr;
    logic [7:0]  w_laneByte;
    logic [15:0] w_laneHalf;
    logic [31:0] w_loadData;
    logic [31:0] w_mergeData;

    assign w_offsetAddr = req_addr - BASE_ADDR;
    assign w_index      = w_offsetAddr >> 2;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == SIZE_HALF) && req_addr[0]) ||
                        ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_reqErr = (req_addr < BASE_ADDR) ||
                      (w_index >= 32'(MEM_WORDS)) ||
                      (req_size == SIZE_RSVD) ||
                      w_misalign;

    always_comb begin
        w_laneByte = ram_rdata[7:0];
        case (r_off)
            2'd0:    w_laneByte = ram_rdata[7:0];
            2'd1:    w_laneByte = ram_rdata[15:8];
            2'd2:    w_laneByte = ram_rdata[23:16];
            default: w_laneByte = ram_rdata[31:24];
        endcase
        w_laneHalf = r_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    end

    always_comb begin
        w_loadData = ram_rdata;
        case (r_size)
            SIZE_BYTE: w_loadData = {{24{r_signed & w_laneByte[7]}}, w_laneByte};
            SIZE_HALF: w_loadData = {{16{r_signed & w_laneHalf[15]}}, w_laneHalf};
            default:   w_loadData = ram_rdata;
        endcase
    end

    // Replace only the addressed lane of the word captured during ACCESS.
    always_comb begin
        w_mergeData = r_merge;
        if (r_size == SIZE_BYTE) begin
            case (r_off)
                2'd0:    w_mergeData[7:0]   = r_wdata[7:0];
                2'd1:    w_mergeData[15:8]  = r_wdata[7:0];
                2'd2:    w_mergeData[23:16] = r_wdata[7:0];
                default: w_mergeData[31:24] = r_wdata[7:0];
            endcase
        end else if (r_off[1]) begin
            w_mergeData[31:16] = r_wdata[15:0];
        end else begin
            w_mergeData[15:0] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        ram_we      = 1'b0;
        ram_wdata   = 32'h0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_nextState = w_reqErr ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (r_we && (r_size == SIZE_WORD)) begin
                    ram_we      = 1'b1;
                    ram_wdata   = r_wdata;
                    w_nextState = RESP;
                end else if (r_we) begin
                    w_nextState = MERGE;
                end else begin
                    w_nextState = RESP;
                end
            end
            MERGE: begin
                ram_we      = 1'b1;
                ram_wdata   = w_mergeData;
                w_nextState = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
        // A write must never commit in a cycle where reset is asserted.
        if (reset) begin
            ram_we    = 1'b0;
            ram_wdata = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ramAddr  <= 32'h0;
            r_wdata    <= 32'h0;
            r_merge    <= 32'h0;
            r_rspRdata <= 32'h0;
            r_rspErr   <= 1'b0;
            r_off      <= 2'b00;
            r_size     <= 2'b00;
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
        end else begin
            if ((r_state == IDLE) && req_valid) begin
                r_off      <= req_addr[1:0];
                r_size     <= req_size;
                r_we       <= req_we;
                r_signed   <= req_signed;
                r_wdata    <= req_wdata;
                r_rspRdata <= 32'h0;
                r_rspErr   <= w_reqErr;
                if (!w_reqErr) begin
                    r_ramAddr <= w_index;
                end
            end else if (r_state == ACCESS) begin
                if (!r_we) begin
                    r_rspRdata <= w_loadData;
                end else if (r_size != SIZE_WORD) begin
                    r_merge <= ram_rdata;
                end
            end
        end
    end

    assign ram_addr  = r_ramAddr;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural 512-word RAM.
// Covers word/sub-word stores, extended loads, range errors, response stalls and mid-operation reset.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:511] = '{default: 32'h0};
    int          weCount = 0;
    logic [31:0] lastAddr = 32'h0;
    logic [31:0] lastData = 32'h0;

    int tests  = 0;
    int failed = 0;

    mem_access_unit #(
        .MEM_WORDS(512),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_signed(req_signed),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[8:0]];

    // The RAM knows nothing of reset: any ram_we pulse is a real write.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[8:0]] <= ram_wdata;
            weCount  <= weCount + 1;
            lastAddr <= ram_addr;
            lastData <= ram_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one request at a negedge, then count cycles until rsp_valid (N+1 is latency 1).
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                                 input logic [1:0] size, input logic sgn, output int latency);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_wdata  = wdata;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        @(negedge clk);
        req_valid = 1'b0;
        latency   = 1;
        while (!rsp_valid && latency < 10) begin
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic completeResponse(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({tag, " req_ready after handshake"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int weBefore;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset ram_addr", ram_addr, 32'h0);
        checkOutput("reset ram_wdata", ram_wdata, 32'h0);
        checkOutput("reset ram_we", 32'(ram_we), 32'd0);

        $display("[TB] word store 0x10");
        weBefore = weCount;
        applyStimulus(32'h10, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, lat);
        checkOutput("wstore latency", 32'(lat), 32'd2);
        checkOutput("wstore rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("wstore rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("wstore write count", 32'(weCount - weBefore), 32'd1);
        checkOutput("wstore ram_addr", lastAddr, 32'd4);
        checkOutput("wstore ram_wdata", lastData, 32'hDEADBEEF);
        completeResponse("wstore");

        $display("[TB] byte loads 0x13");
        weBefore = weCount;
        applyStimulus(32'h13, 32'h0, 1'b0, 2'b00, 1'b1, lat);
        checkOutput("lb signed latency", 32'(lat), 32'd2);
        checkOutput("lb signed rdata", rsp_rdata, 32'hFFFFFFDE);
        checkOutput("lb signed err", 32'(rsp_err), 32'd0);
        completeResponse("lb signed");
        applyStimulus(32'h13, 32'h0, 1'b0, 2'b00, 1'b0, lat);
        checkOutput("lbu rdata", rsp_rdata, 32'h000000DE);
        completeResponse("lbu");
        checkOutput("loads no write", 32'(weCount - weBefore), 32'd0);

        $display("[TB] half store 0x12");
        weBefore = weCount;
        applyStimulus(32'h12, 32'hA5A51234, 1'b1, 2'b01, 1'b0, lat);
        checkOutput("hstore latency", 32'(lat), 32'd3);
        checkOutput("hstore write count", 32'(weCount - weBefore), 32'd1);
        checkOutput("hstore ram_addr", lastAddr, 32'd4);
        checkOutput("hstore ram_wdata", lastData, 32'h1234BEEF);
        checkOutput("hstore rsp_err", 32'(rsp_err), 32'd0);
        completeResponse("hstore");

        $display("[TB] byte store 0x11 then signed half load 0x10");
        applyStimulus(32'h11, 32'hFFFFFFC3, 1'b1, 2'b00, 1'b0, lat);
        checkOutput("bstore latency", 32'(lat), 32'd3);
        checkOutput("bstore ram_wdata", lastData, 32'h1234C3EF);
        completeResponse("bstore");
        applyStimulus(32'h10, 32'h0, 1'b0, 2'b01, 1'b1, lat);
        checkOutput("lh signed rdata", rsp_rdata, 32'hFFFFC3EF);
        completeResponse("lh signed");
        applyStimulus(32'h12, 32'h0, 1'b0, 2'b01, 1'b0, lat);
        checkOutput("lhu upper rdata", rsp_rdata, 32'h00001234);
        completeResponse("lhu upper");

        $display("[TB] error requests");
        weBefore = weCount;
        applyStimulus(32'h800, 32'h11111111, 1'b1, 2'b10, 1'b0, lat);
        checkOutput("range err latency", 32'(lat), 32'd1);
        checkOutput("range err flag", 32'(rsp_err), 32'd1);
        checkOutput("range err rdata", rsp_rdata, 32'h0);
        completeResponse("range err");
        applyStimulus(32'h10, 32'h22222222, 1'b1, 2'b11, 1'b0, lat);
        checkOutput("size err latency", 32'(lat), 32'd1);
        checkOutput("size err flag", 32'(rsp_err), 32'd1);
        checkOutput("size err rdata", rsp_rdata, 32'h0);
        completeResponse("size err");
        checkOutput("errors no write", 32'(weCount - weBefore), 32'd0);
        checkOutput("errors mem intact", mem[4], 32'h1234C3EF);

        $display("[TB] response stall");
        applyStimulus(32'h10, 32'h0, 1'b0, 2'b10, 1'b0, lat);
        checkOutput("stall latency", 32'(lat), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall rsp_rdata", rsp_rdata, 32'h1234C3EF);
            checkOutput("stall rsp_err", 32'(rsp_err), 32'd0);
            checkOutput("stall req_ready", 32'(req_ready), 32'd0);
        end
        completeResponse("stall");

        $display("[TB] reset during merge");
        weBefore   = weCount;
        req_valid  = 1'b1;
        req_addr   = 32'h14;
        req_wdata  = 32'h0000FFFF;
        req_we     = 1'b1;
        req_size   = 2'b01;
        req_signed = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("merge reset ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("merge reset no write", 32'(weCount - weBefore), 32'd0);
        checkOutput("merge reset mem5", mem[5], 32'h0);
        checkOutput("merge reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("merge reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("merge reset ram_addr", ram_addr, 32'h0);
        checkOutput("merge reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("merge reset rsp_err", 32'(rsp_err), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("merge reset response dropped", 32'(rsp_valid), 32'd0);

        $display("[TB] misaligned word load 0x11");
        applyStimulus(32'h11, 32'h0, 1'b0, 2'b10, 1'b0, lat);
`ifdef MISALIGN_TRAP_EN
        checkOutput("misalign latency", 32'(lat), 32'd1);
        checkOutput("misalign err", 32'(rsp_err), 32'd1);
        checkOutput("misalign rdata", rsp_rdata, 32'h0);
`else
        checkOutput("misalign latency", 32'(lat), 32'd2);
        checkOutput("misalign err", 32'(rsp_err), 32'd0);
        checkOutput("misalign rdata", rsp_rdata, 32'h1234C3EF);
`endif
        completeResponse("misalign");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
